// File: rtl/tlp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tlp_tx_arbiter
//
// Purpose:
//   Merges TLP streams from two sources (A, e.g. the completion generator, and
//   B, e.g. the DMA write engine) onto the single FPGA->Host tx pipe of the
//   PCIe core. Arbitration is packet-atomic: once a source's SOP beat has been
//   granted, that source owns the pipe until its EOP beat. A single registered
//   output stage gives 1-cycle latency at full throughput.
//
// Parameters:
//   FIXED_PRIO     0: round-robin between A and B on a tie; 1: A always wins.
//   MAX_PKT_BEATS  0: no length limit; N>0: the N-th beat of a packet that has
//                  not ended is sent with EOP forced and the packet is aborted.
//                  N must fit in 16 bits.
//
// Ports:
//   pcieClk_in      single clock, rising edge
//   reset_in        synchronous, active-high
//   aData_in/aSOP_in/aEOP_in/aValid_in, aReady_out   source A beat interface
//   bData_in/bSOP_in/bEOP_in/bValid_in, bReady_out   source B beat interface
//   txData_out/txSOP_out/txEOP_out/txValid_out       merged beat to PCIe core
//   txReady_in      PCIe core accepts a beat when txValid_out && txReady_in
//   abortCount_out  count of force-terminated packets, saturates at 0xFFFF
//
// Optional build macro TLP_ARB_TRACE_EN:
//   Adds grantState_out[1:0] (0=IDLE, 1=FWD_A, 2=FWD_B, registered state) for
//   SignalTap, plus a simulation assertion that the two Readys are never both
//   high. Without the macro the port and assertion are absent and behaviour
//   is identical.
// ---------------------------------------------------------------------------
module tlp_tx_arbiter #(
  parameter int FIXED_PRIO    = 0,
  parameter int MAX_PKT_BEATS = 0
) (
  input  logic        pcieClk_in,
  input  logic        reset_in,
  input  logic [63:0] aData_in,
  input  logic        aSOP_in,
  input  logic        aEOP_in,
  input  logic        aValid_in,
  output logic        aReady_out,
  input  logic [63:0] bData_in,
  input  logic        bSOP_in,
  input  logic        bEOP_in,
  input  logic        bValid_in,
  output logic        bReady_out,
  output logic [63:0] txData_out,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output logic        txValid_out,
  input  logic        txReady_in,
`ifdef TLP_ARB_TRACE_EN
  output logic [1:0]  grantState_out,
`endif
  output logic [15:0] abortCount_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD_A = 2'd1,
    FWD_B = 2'd2
  } state_t;

  localparam logic [15:0] MAX_BEATS = 16'(MAX_PKT_BEATS);
  localparam bit          LIMIT_EN  = (MAX_PKT_BEATS > 0);
  localparam bit          PRIO_A    = (FIXED_PRIO != 0);

  state_t      r_state;
  logic        r_lastGrantB;
  logic [15:0] r_beatCnt;
  logic [15:0] r_abortCount;
  logic [63:0] r_txData;
  logic        r_txSOP;
  logic        r_txEOP;
  logic        r_txValid;

  logic        w_slotFree;
  logic        w_selA;
  logic        w_selB;
  logic        w_drop;
  logic [63:0] w_data;
  logic        w_sop;
  logic        w_eop;
  logic        w_valid;
  logic        w_accept;
  logic        w_fwd;
  logic [15:0] w_beatNum;
  logic        w_force;

  assign w_slotFree = !r_txValid || txReady_in;

  // Source selection. In IDLE only SOP beats compete for the pipe; when no
  // SOP is on offer, a stray non-SOP beat is selected so it can be swallowed,
  // A first. A SOP candidate always takes precedence over a stray beat.
  always_comb begin
    w_selA = 1'b0;
    w_selB = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      FWD_A: w_selA = 1'b1;
      FWD_B: w_selB = 1'b1;
      default: begin
        if (aValid_in && aSOP_in && bValid_in && bSOP_in) begin
          if (PRIO_A || r_lastGrantB) w_selA = 1'b1;
          else                        w_selB = 1'b1;
        end else if (aValid_in && aSOP_in) begin
          w_selA = 1'b1;
        end else if (bValid_in && bSOP_in) begin
          w_selB = 1'b1;
        end else if (aValid_in) begin
          w_selA = 1'b1;
          w_drop = 1'b1;
        end else if (bValid_in) begin
          w_selB = 1'b1;
          w_drop = 1'b1;
        end
      end
    endcase
  end

  // Beat mux and handshake. Ready goes only to the selected source, so the
  // two Readys are mutually exclusive by construction.
  always_comb begin
    w_data  = 64'd0;
    w_sop   = 1'b0;
    w_eop   = 1'b0;
    w_valid = 1'b0;
    if (w_selA) begin
      w_data  = aData_in;
      w_sop   = aSOP_in;
      w_eop   = aEOP_in;
      w_valid = aValid_in;
    end else if (w_selB) begin
      w_data  = bData_in;
      w_sop   = bSOP_in;
      w_eop   = bEOP_in;
      w_valid = bValid_in;
    end
  end

  assign aReady_out = w_selA && w_slotFree;
  assign bReady_out = w_selB && w_slotFree;
  assign w_accept   = w_valid && w_slotFree;
  assign w_fwd      = w_accept && !w_drop;

  // A forwarded beat taken in IDLE is always the SOP, i.e. beat 1.
  assign w_beatNum = (r_state == IDLE) ? 16'd1 : (r_beatCnt + 16'd1);
  assign w_force   = LIMIT_EN && w_fwd && (w_beatNum == MAX_BEATS) && !w_eop;

  // Output stage, arbitration state and abort counter. A forced EOP ends the
  // packet exactly like a real EOP, so the source's leftover beats reach IDLE
  // as non-SOP beats and are dropped there.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_lastGrantB <= 1'b1;
      r_beatCnt    <= 16'd0;
      r_abortCount <= 16'd0;
      r_txData     <= 64'd0;
      r_txSOP      <= 1'b0;
      r_txEOP      <= 1'b0;
      r_txValid    <= 1'b0;
    end else begin
      if (w_fwd) begin
        r_txValid <= 1'b1;
        r_txData  <= w_data;
        r_txSOP   <= w_sop;
        r_txEOP   <= w_eop || w_force;
      end else if (txReady_in) begin
        r_txValid <= 1'b0;
      end

      if (w_fwd) begin
        if (w_eop || w_force) begin
          r_state      <= IDLE;
          r_lastGrantB <= w_selB;
          r_beatCnt    <= 16'd0;
        end else begin
          r_state   <= w_selA ? FWD_A : FWD_B;
          r_beatCnt <= w_beatNum;
        end
      end

      if (w_force && (r_abortCount != 16'hFFFF)) begin
        r_abortCount <= r_abortCount + 16'd1;
      end
    end
  end

  assign txData_out     = r_txData;
  assign txSOP_out      = r_txSOP;
  assign txEOP_out      = r_txEOP;
  assign txValid_out    = r_txValid;
  assign abortCount_out = r_abortCount;

`ifdef TLP_ARB_TRACE_EN
  assign grantState_out = r_state;

`ifndef SYNTHESIS
  // Mutual exclusion of the Readys guards against beat interleaving.
  readyExclusive: assert property (@(posedge pcieClk_in) disable iff (reset_in)
    !(aReady_out && bReady_out));
`endif
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlp_tx_arbiter
//
// Directed bench for tlp_tx_arbiter (FIXED_PRIO=0, MAX_PKT_BEATS=4).
// Stimulus pushes the hand-computed tx beat sequence into a scoreboard queue;
// a monitor pops and compares every beat the core accepts on the tx pipe.
// Point checks cover reset state, latency, stalls, abort count and reset.
// ---------------------------------------------------------------------------
module tb_tlp_tx_arbiter;

  logic        pcieClk_in = 1'b0;
  logic        reset_in   = 1'b1;
  logic [63:0] aData_in   = 64'd0;
  logic        aSOP_in    = 1'b0;
  logic        aEOP_in    = 1'b0;
  logic        aValid_in  = 1'b0;
  logic        aReady_out;
  logic [63:0] bData_in   = 64'd0;
  logic        bSOP_in    = 1'b0;
  logic        bEOP_in    = 1'b0;
  logic        bValid_in  = 1'b0;
  logic        bReady_out;
  logic [63:0] txData_out;
  logic        txSOP_out;
  logic        txEOP_out;
  logic        txValid_out;
  logic        txReady_in = 1'b1;
  logic [15:0] abortCount_out;

  int vecCount  = 0;
  int missCount = 0;

  logic [65:0] expQ[$];
  logic [65:0] expBeat;

  tlp_tx_arbiter #(
    .FIXED_PRIO    (0),
    .MAX_PKT_BEATS (4)
  ) dut (
    .pcieClk_in     (pcieClk_in),
    .reset_in       (reset_in),
    .aData_in       (aData_in),
    .aSOP_in        (aSOP_in),
    .aEOP_in        (aEOP_in),
    .aValid_in      (aValid_in),
    .aReady_out     (aReady_out),
    .bData_in       (bData_in),
    .bSOP_in        (bSOP_in),
    .bEOP_in        (bEOP_in),
    .bValid_in      (bValid_in),
    .bReady_out     (bReady_out),
    .txData_out     (txData_out),
    .txSOP_out      (txSOP_out),
    .txEOP_out      (txEOP_out),
    .txValid_out    (txValid_out),
    .txReady_in     (txReady_in),
    .abortCount_out (abortCount_out)
  );

  always #5 pcieClk_in = ~pcieClk_in;

  // Monitor: every beat the core accepts must be the next expected beat.
  always @(negedge pcieClk_in) begin
    if (!reset_in && txValid_out && txReady_in) begin
      vecCount = vecCount + 1;
      if (expQ.size() == 0) begin
        missCount = missCount + 1;
        $display("[TB] FAIL txBeat: got data=0x%0h sop=%0b eop=%0b, expected no beat",
                 txData_out, txSOP_out, txEOP_out);
      end else begin
        expBeat = expQ.pop_front();
        if ({txData_out, txSOP_out, txEOP_out} !== expBeat) begin
          missCount = missCount + 1;
          $display("[TB] FAIL txBeat: got data=0x%0h sop=%0b eop=%0b, expected data=0x%0h sop=%0b eop=%0b",
                   txData_out, txSOP_out, txEOP_out, expBeat[65:2], expBeat[1], expBeat[0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vecCount = vecCount + 1;
    if (actual !== expected) begin
      missCount = missCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [63:0] d, input logic sop, input logic eop);
    expQ.push_back({d, sop, eop});
  endtask

  task automatic pushPkt(input logic [63:0] first, input int n);
    for (int i = 0; i < n; i++) pushExp(first + 64'(i), i == 0, i == n - 1);
  endtask

  // Present one beat on source src (0=A, 1=B) and hold it until accepted.
  // Returns 1 time unit after the accepting clock edge.
  task automatic applyStimulus(input bit src, input logic [63:0] d,
                               input logic sop, input logic eop);
    int waitCycles = 0;
    bit accepted   = 1'b0;
    if (src == 1'b0) begin
      aData_in = d; aSOP_in = sop; aEOP_in = eop; aValid_in = 1'b1;
    end else begin
      bData_in = d; bSOP_in = sop; bEOP_in = eop; bValid_in = 1'b1;
    end
    while (!accepted && waitCycles < 200) begin
      @(negedge pcieClk_in);
      accepted = (src == 1'b0) ? aReady_out : bReady_out;
      waitCycles++;
    end
    @(posedge pcieClk_in);
    #1;
    if (!accepted) begin
      vecCount  = vecCount + 1;
      missCount = missCount + 1;
      $display("[TB] FAIL handshake src=%0d data=0x%0h: got no ready, expected ready within 200 cycles",
               src, d);
    end
    if (src == 1'b0) aValid_in = 1'b0;
    else             bValid_in = 1'b0;
  endtask

  task automatic sendPkt(input bit src, input logic [63:0] first, input int n);
    for (int i = 0; i < n; i++) applyStimulus(src, first + 64'(i), i == 0, i == n - 1);
  endtask

  task automatic applyReset();
    reset_in   = 1'b1;
    aValid_in  = 1'b0;
    bValid_in  = 1'b0;
    txReady_in = 1'b1;
    repeat (2) @(posedge pcieClk_in);
    #1;
    reset_in = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge pcieClk_in);
    #1;
  endtask

  initial begin
    // Reset state
    applyReset();
    @(negedge pcieClk_in);
    checkOutput("reset txValid", 64'(txValid_out), 64'd0);
    checkOutput("reset txSOP", 64'(txSOP_out), 64'd0);
    checkOutput("reset txEOP", 64'(txEOP_out), 64'd0);
    checkOutput("reset txData", txData_out, 64'd0);
    checkOutput("reset abortCount", 64'(abortCount_out), 64'd0);
    checkOutput("reset aReady idle", 64'(aReady_out), 64'd0);
    idleCycles(1);

    // T1: single 3-beat TLP from A, 1-cycle latency
    pushPkt(64'h11, 3);
    applyStimulus(1'b0, 64'h11, 1'b1, 1'b0);
    checkOutput("T1 latency txValid", 64'(txValid_out), 64'd1);
    checkOutput("T1 latency txData", txData_out, 64'h11);
    applyStimulus(1'b0, 64'h12, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h13, 1'b0, 1'b1);
    idleCycles(3);

    // T2: tie after reset goes to A; A's back-to-back SOP then ties with B,
    // which wins because A was granted last
    applyReset();
    pushPkt(64'h21, 2);
    pushPkt(64'h31, 2);
    pushPkt(64'h23, 1);
    fork
      begin
        sendPkt(1'b0, 64'h21, 2);
        sendPkt(1'b0, 64'h23, 1);
      end
      sendPkt(1'b1, 64'h31, 2);
    join
    idleCycles(3);

    // T3: B's SOP mid-A-packet is stalled until A's EOP
    pushPkt(64'h61, 3);
    pushPkt(64'h71, 1);
    fork
      sendPkt(1'b0, 64'h61, 3);
      begin
        @(posedge pcieClk_in);
        #1;
        fork
          applyStimulus(1'b1, 64'h71, 1'b1, 1'b1);
          begin
            @(negedge pcieClk_in);
            checkOutput("T3 bReady mid-A", 64'(bReady_out), 64'd0);
          end
        join
      end
    join
    idleCycles(3);

    // T4: 5-cycle backpressure during a 4-beat B packet
    pushPkt(64'h81, 4);
    fork
      sendPkt(1'b1, 64'h81, 4);
      begin
        repeat (2) @(posedge pcieClk_in);
        #1;
        txReady_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge pcieClk_in);
          checkOutput("T4 txData held", txData_out, 64'h82);
        end
        checkOutput("T4 bReady stalled", 64'(bReady_out), 64'd0);
        @(posedge pcieClk_in);
        #1;
        txReady_in = 1'b1;
      end
    join
    idleCycles(3);

    // T5: 6 beats without EOP, limit 4 -> beat 4 forced EOP, 5-6 dropped
    checkOutput("T5 abortCount before", 64'(abortCount_out), 64'd0);
    pushExp(64'h91, 1'b1, 1'b0);
    pushExp(64'h92, 1'b0, 1'b0);
    pushExp(64'h93, 1'b0, 1'b0);
    pushExp(64'h94, 1'b0, 1'b1);
    pushExp(64'hA1, 1'b1, 1'b1);
    applyStimulus(1'b0, 64'h91, 1'b1, 1'b0);
    for (int i = 2; i <= 6; i++) applyStimulus(1'b0, 64'h90 + 64'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 64'hA1, 1'b1, 1'b1);
    idleCycles(3);
    checkOutput("T5 abortCount after", 64'(abortCount_out), 64'd1);

    // T6: reset mid-packet discards the held beat, then a fresh B TLP
    pushExp(64'hB1, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'hB1, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'hB2, 1'b0, 1'b0);
    txReady_in = 1'b0;
    reset_in   = 1'b1;
    @(posedge pcieClk_in);
    #1;
    reset_in   = 1'b0;
    txReady_in = 1'b1;
    @(negedge pcieClk_in);
    checkOutput("T6 txValid after reset", 64'(txValid_out), 64'd0);
    checkOutput("T6 abortCount after reset", 64'(abortCount_out), 64'd0);
    idleCycles(1);
    pushExp(64'hC1, 1'b1, 1'b1);
    applyStimulus(1'b1, 64'hC1, 1'b1, 1'b1);
    @(negedge pcieClk_in);
    checkOutput("T6 fresh txSOP", 64'(txSOP_out), 64'd1);
    checkOutput("T6 fresh txEOP", 64'(txEOP_out), 64'd1);
    idleCycles(4);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
